// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath/memory.
// The master side is the sequencer; the slave side is the datapath that consumes the strobes.
interface multi_cycle_ctrl_if;
    logic [5:0] op_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       mem_ready_i;

    logic       mem_req_o;
    logic       iord_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       pc_write_o;
    logic [1:0] pc_src_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic       zero_ext_o;
    logic [3:0] alu_control_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       reg_write_o;
    logic       instr_done_o;
    logic       illegal_o;
    logic       halted_o;

    modport master (
        input  op_i, funct_i, zero_i, mem_ready_i,
        output mem_req_o, iord_o, mem_write_o, ir_write_o, pc_write_o, pc_src_o,
               alu_src_a_o, alu_src_b_o, zero_ext_o, alu_control_o, reg_dst_o,
               mem_to_reg_o, reg_write_o, instr_done_o, illegal_o, halted_o
    );

    modport slave (
        output op_i, funct_i, zero_i, mem_ready_i,
        input  mem_req_o, iord_o, mem_write_o, ir_write_o, pc_write_o, pc_src_o,
               alu_src_a_o, alu_src_b_o, zero_ext_o, alu_control_o, reg_dst_o,
               mem_to_reg_o, reg_write_o, instr_done_o, illegal_o, halted_o
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS sequencer: one FSM drives the shared ALU, unified memory port and register file.
// Only the state is registered; every control output decodes combinationally from state and inputs.
module multi_cycle_ctrl #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter bit ILLEGAL_HALT  = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    multi_cycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_ALU_WB  = 4'd7,
        S_EXEC_I  = 4'd8,
        S_IMM_WB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;

    state_t state, state_next;

    logic       mem_ok;
    logic       funct_ok;
    logic [3:0] r_alu;
    logic [3:0] i_alu;
    logic       i_zext;

    logic       mem_req, iord, mem_write, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [3:0] alu_control;
    logic       reg_dst, mem_to_reg, reg_write;
    logic       instr_done, illegal, halted;

    assign mem_ok = USE_MEM_READY ? bus.mem_ready_i : 1'b1;

    // R-type function decode; funct_ok also drives illegal detection in DECODE
    always_comb begin
        funct_ok = 1'b1;
        r_alu    = ALU_AND;
        case (bus.funct_i)
            FN_SLL:  r_alu = ALU_SLL;
            FN_SRL:  r_alu = ALU_SRL;
            FN_SRA:  r_alu = ALU_SRA;
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_SLT:  r_alu = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    // Immediate ALU op; IR is stable, so IMM_WB re-derives the same op and extension as EXEC_I
    always_comb begin
        i_alu  = ALU_ADD;
        i_zext = 1'b0;
        case (bus.op_i)
            OP_ANDI: begin i_alu = ALU_AND; i_zext = 1'b1; end
            OP_ORI:  begin i_alu = ALU_OR;  i_zext = 1'b1; end
            OP_SLTI: i_alu = ALU_SLT;
            default: i_alu = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_FETCH;
        else         state <= state_next;
    end

    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        zero_ext    = 1'b0;
        alu_control = ALU_AND;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;

        // Outputs are held at zero for the whole reset interval, even mid-access
        if (rst_ni) begin
            case (state)
                S_FETCH: begin
                    mem_req     = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    if (mem_ok) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b   = 2'b11;
                    alu_control = ALU_ADD;
                    case (bus.op_i)
                        OP_LW, OP_SW: state_next = S_MEM_ADR;
                        OP_R: begin
                            if (funct_ok) begin
                                state_next = S_EXEC_R;
                            end else begin
                                illegal    = 1'b1;
                                state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                            end
                        end
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_EXEC_I;
                        OP_BEQ:  state_next = S_BRANCH;
                        OP_J:    state_next = S_JUMP;
                        default: begin
                            illegal    = 1'b1;
                            state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                    state_next  = (bus.op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ok) state_next = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEM_WR: begin
                    // Write strobe stays up through wait states so the memory sees a stable request
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ok) begin
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a   = 1'b1;
                    alu_control = r_alu;
                    state_next  = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_EXEC_I: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = i_alu;
                    zero_ext    = i_zext;
                    state_next  = S_IMM_WB;
                end
                S_IMM_WB: begin
                    alu_control = i_alu;
                    zero_ext    = i_zext;
                    reg_write   = 1'b1;
                    instr_done  = 1'b1;
                    state_next  = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = ALU_SUB;
                    pc_src      = 2'b01;
                    pc_write    = bus.zero_i;
                    instr_done  = 1'b1;
                    state_next  = S_FETCH;
                end
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

    assign bus.mem_req_o     = mem_req;
    assign bus.iord_o        = iord;
    assign bus.mem_write_o   = mem_write;
    assign bus.ir_write_o    = ir_write;
    assign bus.pc_write_o    = pc_write;
    assign bus.pc_src_o      = pc_src;
    assign bus.alu_src_a_o   = alu_src_a;
    assign bus.alu_src_b_o   = alu_src_b;
    assign bus.zero_ext_o    = zero_ext;
    assign bus.alu_control_o = alu_control;
    assign bus.reg_dst_o     = reg_dst;
    assign bus.mem_to_reg_o  = mem_to_reg;
    assign bus.reg_write_o   = reg_write;
    assign bus.instr_done_o  = instr_done;
    assign bus.illegal_o     = illegal;
    assign bus.halted_o      = halted;

endmodule
